// File: rtl/dmem_responder.sv
// Data-memory bus target: accepts one load/store at a time, waits a fixed number
// of cycles, then returns read data or a write acknowledge (with fault flag).
module dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_ready_reg, req_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              we_reg, we_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [3:0]        be_reg, be_next;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word_reg;
    logic [IDX_W-1:0]  lat_idx, rd_idx;
    logic [3:0]        lane_we;
    logic              accept, commit, fault;

    assign accept = (state_reg == IDLE) && req_valid && req_ready_reg;
    assign commit = (state_reg == WAIT) && (cnt_reg == '0);
    assign fault  = (addr_reg[1:0] != 2'b00) || (addr_reg < ADDR_BASE) ||
                    (((addr_reg - ADDR_BASE) >> 2) >= 32'(DEPTH));

    // The RAM read is issued from the incoming address while idle so the word is
    // already registered by the commit edge, even with zero wait states.
    assign lat_idx = IDX_W'((addr_reg - ADDR_BASE) >> 2);
    assign rd_idx  = (state_reg == IDLE) ? IDX_W'((req_addr - ADDR_BASE) >> 2) : lat_idx;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = commit && we_reg && !fault && be_reg[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[lat_idx][8*i +: 8] <= wdata_reg[8*i +: 8];
            end
        end
        rd_word_reg <= mem[rd_idx];
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_ready_next = req_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        be_next        = be_reg;
        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (accept) begin
                    we_next        = req_we;
                    addr_next      = req_addr;
                    wdata_next     = req_wdata;
                    be_next        = req_be;
                    req_ready_next = 1'b0;
                    cnt_next       = CNT_W'(WAIT_CYCLES);
                    state_next     = WAIT;
                end
            end
            WAIT: begin
                if (commit) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = fault;
                    rsp_rdata_next = (fault || we_reg) ? 32'h0 : rd_word_reg;
                    state_next     = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = 32'h0;
                    req_ready_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'h0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            be_reg        <= be_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
